aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl_if.sv | 37 +++
 rtl/aes_round_ctrl.sv | 142 ++++++++++++++
 tb/tb_aes_round_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_round_ctrl_if.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl_if
// Purpose : Bundles the handshake and datapath-control signals of the AES
//           round controller.
// Signals : start, round_out, out_ready    -- requester / datapath to controller
//           busy, sel, state_en, round_num,
//           first_round, last_round, rcon,
//           out_valid, data_out             -- controller to datapath / consumer
// Modports: slave  -- the controller itself
//           master -- the environment driving and observing the controller
// -----------------------------------------------------------------------------
interface aes_round_ctrl_if;
   logic         start;
   logic [0:127] round_out;
   logic         out_ready;
   logic         busy;
   logic         sel;
   logic         state_en;
   logic [3:0]   round_num;
   logic         first_round;
   logic         last_round;
   logic [7:0]   rcon;
   logic         out_valid;
   logic [0:127] data_out;

   modport slave (
      input  start, round_out, out_ready,
      output busy, sel, state_en, round_num, first_round, last_round,
             rcon, out_valid, data_out
   );

   modport master (
      output start, round_out, out_ready,
      input  busy, sel, state_en, round_num, first_round, last_round,
             rcon, out_valid, data_out
   );
endinterface

// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
// Purpose : Sequences one AES-128 encryption through an external round
//           datapath: one LOAD cycle (AddRoundKey on the input block), ten
//           ROUND cycles, then holds the captured ciphertext until the consumer
//           accepts it.
// Ports   : clk   -- rising-edge clock
//           rst_n -- asynchronous active-low reset
//           bus   -- aes_round_ctrl_if.slave (start/round_out/out_ready in,
//                    busy/sel/state_en/round_num/first_round/last_round/rcon/
//                    out_valid/data_out out)
// -----------------------------------------------------------------------------
module aes_round_ctrl (
   input  logic             clk,
   input  logic             rst_n,
   aes_round_ctrl_if.slave  bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] ROUND = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [3:0] LAST_RND = 4'd10;

   logic [1:0]   state_r;
   logic [1:0]   state_nxt_s;
   logic [3:0]   round_r;
   logic [3:0]   round_nxt_s;
   logic         capture_s;
   logic         sel_r;
   logic         state_en_r;
   logic [7:0]   rcon_r;
   logic         out_valid_r;
   logic [0:127] data_out_r;

   // Key-expansion round constant for rounds 1..10; zero outside that range.
   function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
      logic [7:0] val;
      case (rnd)
         4'd1:    val = 8'h01;
         4'd2:    val = 8'h02;
         4'd3:    val = 8'h04;
         4'd4:    val = 8'h08;
         4'd5:    val = 8'h10;
         4'd6:    val = 8'h20;
         4'd7:    val = 8'h40;
         4'd8:    val = 8'h80;
         4'd9:    val = 8'h1B;
         4'd10:   val = 8'h36;
         default: val = 8'h00;
      endcase
      return val;
   endfunction

   // Next-state, next-round and capture decision.
   always_comb begin
      state_nxt_s = state_r;
      round_nxt_s = round_r;
      capture_s   = 1'b0;
      case (state_r)
         IDLE: begin
            round_nxt_s = 4'd0;
            if (bus.start) begin
               state_nxt_s = LOAD;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         LOAD: begin
            state_nxt_s = ROUND;
            round_nxt_s = 4'd1;
         end
         ROUND: begin
            // Final round: the datapath output is the ciphertext.
            if (round_r == LAST_RND) begin
               state_nxt_s = DONE;
               round_nxt_s = 4'd0;
               capture_s   = 1'b1;
            end else begin
               state_nxt_s = ROUND;
               round_nxt_s = round_r + 4'd1;
            end
         end
         DONE: begin
            round_nxt_s = 4'd0;
            // start is deliberately not looked at here: no queuing.
            if (bus.out_ready) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            round_nxt_s = 4'd0;
         end
      endcase
   end

   // State, round counter and registered control outputs (decoded from the
   // next state so they line up with the state they describe).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         round_r     <= 4'd0;
         sel_r       <= 1'b0;
         state_en_r  <= 1'b0;
         rcon_r      <= 8'h00;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         round_r     <= round_nxt_s;
         sel_r       <= (state_nxt_s == ROUND);
         state_en_r  <= (state_nxt_s == LOAD) || (state_nxt_s == ROUND);
         rcon_r      <= (state_nxt_s == ROUND) ? rcon_of(round_nxt_s) : 8'h00;
         out_valid_r <= (state_nxt_s == DONE);
      end
   end

   // Ciphertext register: loads only on the final-round capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_r <= 128'd0;
      end else if (capture_s) begin
         data_out_r <= bus.round_out;
      end else begin
         data_out_r <= data_out_r;
      end
   end

   assign bus.busy        = (state_r == LOAD) || (state_r == ROUND);
   assign bus.first_round = (state_r == LOAD);
   assign bus.last_round  = (state_r == ROUND) && (round_r == LAST_RND);
   assign bus.sel         = sel_r;
   assign bus.state_en    = state_en_r;
   assign bus.round_num   = round_r;
   assign bus.rcon        = rcon_r;
   assign bus.out_valid   = out_valid_r;
   assign bus.data_out    = data_out_r;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_round_ctrl
// Self-checking bench for aes_round_ctrl. The reference model tracks a single
// integer "step" per block (-1 idle, 0 load, 1..10 rounds, 11 done) and
// derives every expected output from it arithmetically.
// -----------------------------------------------------------------------------
module tb_aes_round_ctrl;

   logic clk;
   logic rst_n;

   aes_round_ctrl_if bus_if ();

   aes_round_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_errors;

   // reference model state
   int           m_step;
   logic [127:0] m_data;
   int           m_completions;

   logic [7:0] rcon_tbl [1:10];

   localparam logic [127:0] CAP_VAL = 128'h3925841d02dc09fbdc118597196a0b32;

   // Count one comparison and report it when it disagrees.
   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Advance the model by one clock edge with the inputs present at that edge.
   task automatic model_edge(input bit st, input bit rdy, input logic [127:0] rout);
      if (m_step == -1) begin
         if (st) m_step = 0;
      end else if (m_step < 10) begin
         m_step = m_step + 1;
      end else if (m_step == 10) begin
         m_data = rout;
         m_step = 11;
      end else begin
         if (rdy) begin
            m_step = -1;
            m_completions++;
         end
      end
   endtask

   task automatic model_reset();
      m_step = -1;
      m_data = 128'd0;
   endtask

   // Compare every DUT output against the model's view of the current step.
   task automatic compare_all();
      int s;
      logic [127:0] dout;
      s = m_step;
      dout = bus_if.data_out;
      check_eq("busy",        bus_if.busy,        (s >= 0 && s <= 10));
      check_eq("sel",         bus_if.sel,         (s >= 1 && s <= 10));
      check_eq("state_en",    bus_if.state_en,    (s >= 0 && s <= 10));
      check_eq("round_num",   bus_if.round_num,   (s >= 0 && s <= 10) ? s : 0);
      check_eq("first_round", bus_if.first_round, (s == 0));
      check_eq("last_round",  bus_if.last_round,  (s == 10));
      check_eq("rcon",        bus_if.rcon,        (s >= 1 && s <= 10) ? rcon_tbl[s] : 8'h00);
      check_eq("out_valid",   bus_if.out_valid,   (s == 11));
      check_eq("data_out",    dout,               m_data);
   endtask

   // One clock: drive inputs (at negedge), take the edge, check at next negedge.
   task automatic cyc(input bit st, input bit rdy, input logic [127:0] rout);
      bus_if.start     = st;
      bus_if.out_ready = rdy;
      bus_if.round_out = rout;
      @(posedge clk);
      model_edge(st, rdy, rout);
      @(negedge clk);
      compare_all();
   endtask

   // Run one block from IDLE: optional start pulses during rounds/DONE,
   // a DONE stall of `stall` cycles, and round_out forced to `cap` in round 10.
   task automatic run_block(input int stall, input bit noisy_start, input logic [127:0] cap);
      int n;
      int held;
      int comp0;
      bit st;
      logic [127:0] rout;
      comp0 = m_completions;
      held = 0;
      cyc(1'b1, 1'b1, rand128());
      n = 0;
      while (m_step != -1 && n < 40) begin
         st = noisy_start && (m_step == 3 || m_step == 7 || m_step == 11);
         rout = (m_step == 10) ? cap : rand128();
         if (m_step == 11 && held < stall) begin
            held++;
            cyc(st, 1'b0, rout);
         end else begin
            cyc(st, 1'b1, rout);
         end
         n++;
      end
      check_eq("block_len", n, 11 + stall + 1);
      check_eq("completions", m_completions - comp0, 1);
   endtask

   initial begin
      int t_load [$];
      int n;
      int cyc_idx;

      rcon_tbl[1] = 8'h01; rcon_tbl[2] = 8'h02; rcon_tbl[3]  = 8'h04;
      rcon_tbl[4] = 8'h08; rcon_tbl[5] = 8'h10; rcon_tbl[6]  = 8'h20;
      rcon_tbl[7] = 8'h40; rcon_tbl[8] = 8'h80; rcon_tbl[9]  = 8'h1B;
      rcon_tbl[10] = 8'h36;

      n_checks = 0;
      n_errors = 0;
      m_completions = 0;
      model_reset();

      bus_if.start     = 1'b0;
      bus_if.out_ready = 1'b0;
      bus_if.round_out = 128'd0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      compare_all();
      rst_n = 1'b1;

      // idle with start low stays idle
      repeat (3) cyc(1'b0, 1'b1, rand128());

      // nominal block with the known final-round value
      run_block(0, 1'b0, CAP_VAL);
      check_eq("cap_value", bus_if.data_out, CAP_VAL);

      // backpressure: 5 stalled DONE cycles, then a start that is ignored
      run_block(5, 1'b0, rand128());
      run_block(5, 1'b1, rand128());
      cyc(1'b0, 1'b1, rand128());
      check_eq("no_requeue", bus_if.busy, 1'b0);

      // asynchronous reset at round 5
      cyc(1'b1, 1'b1, rand128());
      n = 0;
      while (m_step != 5 && n < 20) begin
         cyc(1'b0, 1'b1, rand128());
         n++;
      end
      check_eq("reach_rnd5", bus_if.round_num, 4'd5);
      #2 rst_n = 1'b0;
      #1 model_reset();
      compare_all();
      @(negedge clk);
      compare_all();
      rst_n = 1'b1;
      run_block(0, 1'b0, rand128());

      // back-to-back: start held high, out_ready high
      t_load.delete();
      for (int i = 0; i < 45; i++) begin
         cyc(1'b1, 1'b1, rand128());
         if (bus_if.first_round) t_load.push_back(i);
      end
      check_eq("b2b_loads", t_load.size(), 4);
      for (int i = 1; i < t_load.size(); i++) begin
         check_eq("b2b_period", t_load[i] - t_load[i-1], 13);
      end

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom % 4) == 0, ($urandom % 3) != 0, rand128());
      end

      // drain: bounded wait for idle
      cyc_idx = 0;
      while (m_step != -1 && cyc_idx < 40) begin
         cyc(1'b0, 1'b1, rand128());
         cyc_idx++;
      end
      check_eq("drain_idle", bus_if.busy | bus_if.out_valid, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
